// File: rtl/sdram_cmd_monitor.sv
// sdram_cmd_monitor
// Passive checker on the SDRAM command bus at the device end. Decodes each
// sampled command, tracks which banks hold an open row, and flags tRP, tRCD,
// tRC, tREFI and bank-state violations as single-cycle pulses. A sticky error
// bit and a wrapping REF counter summarise activity for software.
module sdram_cmd_monitor #(
  parameter int unsigned T_RP   = 3,
  parameter int unsigned T_RCD  = 3,
  parameter int unsigned T_RC   = 10,
  parameter int unsigned T_REFI = 1560
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic        dram_cs_n_i,
  input  logic        dram_ras_n_i,
  input  logic        dram_cas_n_i,
  input  logic        dram_we_n_i,
  input  logic [1:0]  dram_ba_i,
  input  logic [12:0] dram_addr_i,
  output logic [3:0]  cmd_code_o,
  output logic        cmd_valid_o,
  output logic [3:0]  bank_open_o,
  output logic        viol_trp_o,
  output logic        viol_trcd_o,
  output logic        viol_trc_o,
  output logic        viol_state_o,
  output logic        viol_refi_o,
  output logic        error_o,
  output logic [15:0] ref_count_o
);

  // Counter widths are just large enough to hold the saturation value.
  localparam int unsigned RP_W   = $clog2(T_RP + 1);
  localparam int unsigned RCD_W  = $clog2(T_RCD + 1);
  localparam int unsigned RC_W   = $clog2(T_RC + 1);
  localparam int unsigned REFI_W = $clog2(T_REFI + 1);

  localparam logic [RP_W-1:0]   RP_MAX    = RP_W'(T_RP);
  localparam logic [RP_W-1:0]   RP_ONE    = RP_W'(1);
  localparam logic [RCD_W-1:0]  RCD_MAX   = RCD_W'(T_RCD);
  localparam logic [RCD_W-1:0]  RCD_ONE   = RCD_W'(1);
  localparam logic [RC_W-1:0]   RC_MAX    = RC_W'(T_RC);
  localparam logic [RC_W-1:0]   RC_ONE    = RC_W'(1);
  localparam logic [REFI_W-1:0] REFI_MAX  = REFI_W'(T_REFI);
  localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI - 1);
  localparam logic [REFI_W-1:0] REFI_ONE  = REFI_W'(1);

  localparam logic [3:0] CODE_NOP = 4'b0111;

  // Decoded command classes
  logic [3:0] cmd_s;
  logic       is_cmd_s;
  logic       is_act_s;
  logic       is_rw_s;
  logic       is_pre_s;
  logic       is_ref_s;
  logic       is_mrs_s;
  logic       pre_all_s;

  // Rule results for the current sample
  logic       any_pre_short_s;
  logic       trp_s;
  logic       trcd_s;
  logic       trc_s;
  logic       state_s;
  logic       refi_s;
  logic       viol_any_s;

  // Only A10 of the address bus matters to this checker.
  logic       unused_addr_s;
  assign unused_addr_s = ^{dram_addr_i[12:11], dram_addr_i[9:0]};

  // State
  logic [3:0]        cmd_code_q;
  logic              cmd_valid_q;
  logic [3:0]        bank_open_q,  bank_open_d;
  logic [RP_W-1:0]   pre_cnt_q [4];
  logic [RP_W-1:0]   pre_cnt_d [4];
  logic [RCD_W-1:0]  act_cnt_q [4];
  logic [RCD_W-1:0]  act_cnt_d [4];
  logic [RC_W-1:0]   ref_cnt_q,    ref_cnt_d;
  logic [REFI_W-1:0] refi_cnt_q,   refi_cnt_d;
  logic              viol_trp_q;
  logic              viol_trcd_q;
  logic              viol_trc_q;
  logic              viol_state_q;
  logic              viol_refi_q;
  logic              error_q,      error_d;
  logic [15:0]       ref_count_q,  ref_count_d;

  // Decode the sampled command bus into command classes; CS high is a deselect.
  always_comb begin
    cmd_s     = {dram_cs_n_i, dram_ras_n_i, dram_cas_n_i, dram_we_n_i};
    is_act_s  = 1'b0;
    is_rw_s   = 1'b0;
    is_pre_s  = 1'b0;
    is_ref_s  = 1'b0;
    is_mrs_s  = 1'b0;
    case (cmd_s)
      4'b0011:          is_act_s = 1'b1;
      4'b0101, 4'b0100: is_rw_s  = 1'b1;
      4'b0010:          is_pre_s = 1'b1;
      4'b0001:          is_ref_s = 1'b1;
      4'b0000:          is_mrs_s = 1'b1;
      default:          is_act_s = 1'b0;
    endcase
    is_cmd_s  = ~dram_cs_n_i & (cmd_s != CODE_NOP);
    pre_all_s = is_pre_s & dram_addr_i[10];
  end

  // Evaluate every rule against the counters as they stood before this edge.
  always_comb begin
    any_pre_short_s = 1'b0;
    for (int b = 0; b < 4; b++) begin
      any_pre_short_s = any_pre_short_s | (pre_cnt_q[b] < RP_MAX);
    end
    trp_s   = enable_i & ((is_act_s & (pre_cnt_q[dram_ba_i] < RP_MAX)) |
                          (is_ref_s & any_pre_short_s));
    trcd_s  = enable_i & is_rw_s & (act_cnt_q[dram_ba_i] < RCD_MAX);
    trc_s   = enable_i & is_cmd_s & (ref_cnt_q < RC_MAX);
    state_s = enable_i & ((is_act_s & bank_open_q[dram_ba_i]) |
                          (is_rw_s & ~bank_open_q[dram_ba_i]) |
                          ((is_ref_s | is_mrs_s) & (bank_open_q != 4'b0000)));
    // Fires on the single edge where the interval counter would reach T_REFI.
    refi_s  = enable_i & ~is_ref_s & (refi_cnt_q == REFI_LAST);
    viol_any_s = trp_s | trcd_s | trc_s | state_s | refi_s;
  end

  // Next-state for bank tracking, saturating timers, sticky error and REF count.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      if (is_act_s && (dram_ba_i == 2'(b))) begin
        bank_open_d[b] = 1'b1;
      end else if (is_pre_s && (pre_all_s || (dram_ba_i == 2'(b)))) begin
        bank_open_d[b] = 1'b0;
      end else begin
        bank_open_d[b] = bank_open_q[b];
      end

      if (is_pre_s && (pre_all_s || (dram_ba_i == 2'(b)))) begin
        pre_cnt_d[b] = RP_ONE;
      end else if (pre_cnt_q[b] < RP_MAX) begin
        pre_cnt_d[b] = pre_cnt_q[b] + RP_ONE;
      end else begin
        pre_cnt_d[b] = pre_cnt_q[b];
      end

      if (is_act_s && (dram_ba_i == 2'(b))) begin
        act_cnt_d[b] = RCD_ONE;
      end else if (act_cnt_q[b] < RCD_MAX) begin
        act_cnt_d[b] = act_cnt_q[b] + RCD_ONE;
      end else begin
        act_cnt_d[b] = act_cnt_q[b];
      end
    end

    if (is_ref_s) begin
      ref_cnt_d = RC_ONE;
    end else if (ref_cnt_q < RC_MAX) begin
      ref_cnt_d = ref_cnt_q + RC_ONE;
    end else begin
      ref_cnt_d = ref_cnt_q;
    end

    // The refresh interval timer idles at zero while checks are disarmed.
    if (!enable_i || is_ref_s) begin
      refi_cnt_d = {REFI_W{1'b0}};
    end else if (refi_cnt_q < REFI_MAX) begin
      refi_cnt_d = refi_cnt_q + REFI_ONE;
    end else begin
      refi_cnt_d = refi_cnt_q;
    end

    // A violation beats a simultaneous clear.
    if (viol_any_s) begin
      error_d = 1'b1;
    end else if (clear_i) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end

    if (clear_i) begin
      ref_count_d = is_ref_s ? 16'd1 : 16'd0;
    end else if (is_ref_s) begin
      ref_count_d = ref_count_q + 16'd1;
    end else begin
      ref_count_d = ref_count_q;
    end
  end

  // Register all state and outputs; timers preset saturated so reset raises no flags.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cmd_code_q   <= CODE_NOP;
      cmd_valid_q  <= 1'b0;
      bank_open_q  <= 4'b0000;
      for (int b = 0; b < 4; b++) begin
        pre_cnt_q[b] <= RP_MAX;
        act_cnt_q[b] <= RCD_MAX;
      end
      ref_cnt_q    <= RC_MAX;
      refi_cnt_q   <= {REFI_W{1'b0}};
      viol_trp_q   <= 1'b0;
      viol_trcd_q  <= 1'b0;
      viol_trc_q   <= 1'b0;
      viol_state_q <= 1'b0;
      viol_refi_q  <= 1'b0;
      error_q      <= 1'b0;
      ref_count_q  <= 16'd0;
    end else begin
      cmd_code_q   <= cmd_s;
      cmd_valid_q  <= is_cmd_s;
      bank_open_q  <= bank_open_d;
      for (int b = 0; b < 4; b++) begin
        pre_cnt_q[b] <= pre_cnt_d[b];
        act_cnt_q[b] <= act_cnt_d[b];
      end
      ref_cnt_q    <= ref_cnt_d;
      refi_cnt_q   <= refi_cnt_d;
      viol_trp_q   <= trp_s;
      viol_trcd_q  <= trcd_s;
      viol_trc_q   <= trc_s;
      viol_state_q <= state_s;
      viol_refi_q  <= refi_s;
      error_q      <= error_d;
      ref_count_q  <= ref_count_d;
    end
  end

  assign cmd_code_o   = cmd_code_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign bank_open_o  = bank_open_q;
  assign viol_trp_o   = viol_trp_q;
  assign viol_trcd_o  = viol_trcd_q;
  assign viol_trc_o   = viol_trc_q;
  assign viol_state_o = viol_state_q;
  assign viol_refi_o  = viol_refi_q;
  assign error_o      = error_q;
  assign ref_count_o  = ref_count_q;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// tb_sdram_cmd_monitor
// Directed scenarios followed by randomized traffic. The reference model keeps
// the cycle index of the most recent PRE/ACT/REF per bank and judges each rule
// by plain timestamp differences.
module tb_sdram_cmd_monitor;

  localparam int T_RP   = 3;
  localparam int T_RCD  = 3;
  localparam int T_RC   = 10;
  localparam int T_REFI = 1560;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_BST = 4'b0110;

  localparam int FAR_PAST = -100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en;
  logic        clr;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;

  logic [3:0]  cmd_code;
  logic        cmd_valid;
  logic [3:0]  bank_open;
  logic        viol_trp, viol_trcd, viol_trc, viol_state, viol_refi;
  logic        error;
  logic [15:0] ref_count;

  always #5 clk = ~clk;

  sdram_cmd_monitor #(
    .T_RP(T_RP), .T_RCD(T_RCD), .T_RC(T_RC), .T_REFI(T_REFI)
  ) dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .enable_i     (en),
    .clear_i      (clr),
    .dram_cs_n_i  (cs_n),
    .dram_ras_n_i (ras_n),
    .dram_cas_n_i (cas_n),
    .dram_we_n_i  (we_n),
    .dram_ba_i    (ba),
    .dram_addr_i  (addr),
    .cmd_code_o   (cmd_code),
    .cmd_valid_o  (cmd_valid),
    .bank_open_o  (bank_open),
    .viol_trp_o   (viol_trp),
    .viol_trcd_o  (viol_trcd),
    .viol_trc_o   (viol_trc),
    .viol_state_o (viol_state),
    .viol_refi_o  (viol_refi),
    .error_o      (error),
    .ref_count_o  (ref_count)
  );

  int total = 0;
  int bad   = 0;
  int refi_pulses = 0;

  // Reference model state: cycle index of last events
  int          n;
  int          last_pre [4];
  int          last_act [4];
  int          last_ref;
  int          refi_start;
  logic [3:0]  m_open;
  logic        m_err;
  logic [15:0] m_refc;
  logic [3:0]  e_code;
  logic        e_valid, e_trp, e_trcd, e_trc, e_state, e_refi;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      last_pre[i] = FAR_PAST;
      last_act[i] = FAR_PAST;
    end
    last_ref   = FAR_PAST;
    refi_start = 0;
    m_open     = 4'b0000;
    m_err      = 1'b0;
    m_refc     = 16'd0;
    e_code     = C_NOP;
    e_valid    = 1'b0;
    e_trp      = 1'b0;
    e_trcd     = 1'b0;
    e_trc      = 1'b0;
    e_state    = 1'b0;
    e_refi     = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] code, input logic [1:0] b, input logic a10);
    logic act, rw, pre, rf, mrs, cmd, short_any;
    int   bi;
    n++;
    bi  = int'(b);
    cmd = !code[3] && (code != C_NOP);
    act = (code == C_ACT);
    rw  = (code == C_RD) || (code == C_WR);
    pre = (code == C_PRE);
    rf  = (code == C_REF);
    mrs = (code == C_MRS);
    short_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (n - last_pre[i] < T_RP) short_any = 1'b1;
    end
    e_trp   = en && ((act && (n - last_pre[bi] < T_RP)) || (rf && short_any));
    e_trcd  = en && rw && (n - last_act[bi] < T_RCD);
    e_trc   = en && cmd && (n - last_ref < T_RC);
    e_state = en && ((act && m_open[bi]) || (rw && !m_open[bi]) ||
                     ((rf || mrs) && (m_open != 4'b0000)));
    e_refi  = en && !rf && (n - refi_start == T_REFI);
    e_code  = code;
    e_valid = cmd;
    if (act) begin
      m_open[bi]   = 1'b1;
      last_act[bi] = n;
    end
    if (pre) begin
      if (a10) begin
        for (int i = 0; i < 4; i++) last_pre[i] = n;
        m_open = 4'b0000;
      end else begin
        last_pre[bi] = n;
        m_open[bi]   = 1'b0;
      end
    end
    if (rf) last_ref = n;
    if (!en || rf) refi_start = n;
    if (e_trp || e_trcd || e_trc || e_state || e_refi) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (clr) m_refc = rf ? 16'd1 : 16'd0;
    else if (rf) m_refc = m_refc + 16'd1;
  endtask

  task automatic check_all();
    check("cmd_code",   16'(cmd_code),   16'(e_code));
    check("cmd_valid",  16'(cmd_valid),  16'(e_valid));
    check("bank_open",  16'(bank_open),  16'(m_open));
    check("viol_trp",   16'(viol_trp),   16'(e_trp));
    check("viol_trcd",  16'(viol_trcd),  16'(e_trcd));
    check("viol_trc",   16'(viol_trc),   16'(e_trc));
    check("viol_state", 16'(viol_state), 16'(e_state));
    check("viol_refi",  16'(viol_refi),  16'(e_refi));
    check("error",      16'(error),      16'(m_err));
    check("ref_count",  ref_count,       m_refc);
  endtask

  task automatic step(input logic [3:0] code, input logic [1:0] b, input logic [12:0] a);
    {cs_n, ras_n, cas_n, we_n} = code;
    ba   = b;
    addr = a;
    model_step(code, b, a[10]);
    @(posedge clk);
    #1;
    check_all();
    if (viol_refi) refi_pulses++;
  endtask

  task automatic nops(input int count);
    for (int i = 0; i < count; i++) step(C_NOP, 2'd0, 13'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_cmd_code",   16'(cmd_code),   16'h0007);
    check("rst_cmd_valid",  16'(cmd_valid),  16'd0);
    check("rst_bank_open",  16'(bank_open),  16'd0);
    check("rst_viols",      16'({viol_trp, viol_trcd, viol_trc, viol_state, viol_refi}), 16'd0);
    check("rst_error",      16'(error),      16'd0);
    check("rst_ref_count",  ref_count,       16'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    en = 1'b1; clr = 1'b0;
    cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = 2'd0; addr = 13'd0;
    #1;
    do_reset();

    // PRE-all, two NOPs, REF: legal
    step(C_PRE, 2'd0, 13'h0400);
    nops(2);
    step(C_REF, 2'd0, 13'd0);
    check("t1_trp",       16'(viol_trp),  16'd0);
    check("t1_ref_count", ref_count,      16'd1);
    check("t1_bank_open", 16'(bank_open), 16'd0);

    // PRE-all, one NOP, REF: tRP violation, sticky error until clear
    step(C_PRE, 2'd0, 13'h0400);
    nops(1);
    step(C_REF, 2'd0, 13'd0);
    check("t2_trp",   16'(viol_trp), 16'd1);
    check("t2_error", 16'(error),    16'd1);
    nops(3);
    check("t2_trp_pulse", 16'(viol_trp), 16'd0);
    check("t2_sticky",    16'(error),    16'd1);
    clr = 1'b1;
    step(C_NOP, 2'd0, 13'd0);
    clr = 1'b0;
    check("t2_cleared",   16'(error), 16'd0);
    check("t2_refc_zero", ref_count,  16'd0);
    // REF together with clear; REF is too close to the previous one
    clr = 1'b1;
    step(C_REF, 2'd0, 13'd0);
    clr = 1'b0;
    check("t2_refc_one",   ref_count,      16'd1);
    check("t2_trc_wins",   16'(viol_trc),  16'd1);
    check("t2_error_wins", 16'(error),     16'd1);

    // REF, five NOPs, ACT bank 2: tRC violation
    nops(12);
    step(C_REF, 2'd0, 13'd0);
    nops(5);
    step(C_ACT, 2'd2, 13'h0123);
    check("t3_trc",       16'(viol_trc),  16'd1);
    check("t3_bank_open", 16'(bank_open), 16'h0004);

    // ACT bank 1, one NOP, READ bank 1: tRCD; then READ closed bank 0
    step(C_ACT, 2'd1, 13'h0044);
    nops(1);
    step(C_RD, 2'd1, 13'd0);
    check("t4_trcd", 16'(viol_trcd), 16'd1);
    step(C_RD, 2'd0, 13'd0);
    check("t4_state", 16'(viol_state), 16'd1);
    step(C_PRE, 2'd0, 13'h0400);
    nops(12);

    // Refresh interval: one pulse at T_REFI cycles, then silence
    step(C_REF, 2'd0, 13'd0);
    refi_pulses = 0;
    nops(T_REFI - 1);
    check("t5_quiet", 16'(refi_pulses), 16'd0);
    nops(1);
    check("t5_pulse", 16'(viol_refi), 16'd1);
    nops(20);
    check("t5_once", 16'(refi_pulses), 16'd1);
    step(C_REF, 2'd0, 13'd0);
    refi_pulses = 0;
    nops(T_REFI - 1);
    check("t5_after_ref", 16'(refi_pulses), 16'd0);

    // Reset in mid-sequence with bank 3 open
    nops(12);
    step(C_ACT, 2'd3, 13'h0010);
    check("t6_open3", 16'(bank_open), 16'h0008);
    nops(1);
    do_reset();
    step(C_ACT, 2'd0, 13'h0001);
    check("t6_noflag", 16'({viol_trp, viol_trcd, viol_trc, viol_state, viol_refi}), 16'd0);
    check("t6_open0",  16'(bank_open), 16'h0001);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int         r;
      logic [3:0] code;
      r   = int'($urandom_range(0, 99));
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 39) == 0);
      if (r < 45)      code = C_NOP;
      else if (r < 50) code = {1'b1, 3'($urandom_range(0, 7))};
      else if (r < 62) code = C_ACT;
      else if (r < 70) code = C_RD;
      else if (r < 76) code = C_WR;
      else if (r < 88) code = C_PRE;
      else if (r < 95) code = C_REF;
      else if (r < 97) code = C_MRS;
      else             code = C_BST;
      step(code, 2'($urandom_range(0, 3)), 13'($urandom));
    end
    en = 1'b1;
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
